// File: rtl/control_signals_if.sv
// ---------------------------------------------------------------------------
// control_signals_if
// Bundle between the microcode sequencer and the core datapath / debug module.
//   master (sequencer side):
//     inputs : mem_complete, opcode[4:0], f3[2:0], branch_taken,
//              halt_req, resume_req, abs_valid, abs_op[4:0]
//     outputs: mcp_addr[4:0], write_pc, write_pc_ne, write_pc_ex, write_ir,
//              write_rd, write_csr, mem_read, mem_write, addr_sel,
//              rd_sel[1:0], alu_insel1[1:0], alu_insel2[1:0],
//              abstract_write, abstract_done, progbuf, halted
//   slave (datapath / debug side): same signals, opposite directions.
// ---------------------------------------------------------------------------
interface control_signals_if;
    logic       mem_complete;
    logic [4:0] opcode;
    logic [2:0] f3;
    logic       branch_taken;
    logic       halt_req;
    logic       resume_req;
    logic       abs_valid;
    logic [4:0] abs_op;

    logic [4:0] mcp_addr;
    logic       write_pc;
    logic       write_pc_ne;
    logic       write_pc_ex;
    logic       write_ir;
    logic       write_rd;
    logic       write_csr;
    logic       mem_read;
    logic       mem_write;
    logic       addr_sel;
    logic [1:0] rd_sel;
    logic [1:0] alu_insel1;
    logic [1:0] alu_insel2;
    logic       abstract_write;
    logic       abstract_done;
    logic       progbuf;
    logic       halted;

    modport master (
        input  mem_complete, opcode, f3, branch_taken,
               halt_req, resume_req, abs_valid, abs_op,
        output mcp_addr, write_pc, write_pc_ne, write_pc_ex, write_ir,
               write_rd, write_csr, mem_read, mem_write, addr_sel,
               rd_sel, alu_insel1, alu_insel2,
               abstract_write, abstract_done, progbuf, halted
    );

    modport slave (
        output mem_complete, opcode, f3, branch_taken,
               halt_req, resume_req, abs_valid, abs_op,
        input  mcp_addr, write_pc, write_pc_ne, write_pc_ex, write_ir,
               write_rd, write_csr, mem_read, mem_write, addr_sel,
               rd_sel, alu_insel1, alu_insel2,
               abstract_write, abstract_done, progbuf, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
// Multicycle microcode sequencer. The 5-bit state (mcp_addr) is the only
// sequencing state besides the program-buffer flag; every datapath strobe and
// select is a Moore decode of it (qualified by mem_complete, branch_taken,
// f3). Handles fetch/dispatch/execute, debug halt/resume and abstract
// commands while halted.
// Ports:
//   clk    core clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   cs     control_signals_if.master (datapath + debug handshake)
// Encodings:
//   addr_sel   0=PC 1=ALU
//   rd_sel     00=ALU 01=MEM 10=CSR
//   alu_insel1 00=RS 01=PC 10=ZR
//   alu_insel2 00=RS 01=IM 10=IS (shift amount)
// Execute states share their code with the RISC-V opcode[6:2] value, so
// DISPATCH loads the opcode straight into mcp_addr; abstract-command states
// share their code with the debug abstract opcode in the same way.
// ---------------------------------------------------------------------------
module control_sequencer #(
    parameter bit RESET_HALTED    = 1'b0,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    control_signals_if.master  cs
);

    typedef enum logic [4:0] {
        LOAD       = 5'b00000,
        LOAD_W     = 5'b00001,
        LOAD_1     = 5'b00010,
        MISCMEM    = 5'b00011,
        OPIMM      = 5'b00100,
        AUIPC      = 5'b00101,
        STORE      = 5'b01000,
        STORE_W    = 5'b01001,
        STORE_1    = 5'b01010,
        OP         = 5'b01100,
        LUI        = 5'b01101,
        PROLOGUE   = 5'b10000,
        DISPATCH   = 5'b10001,
        HALTED     = 5'b10010,
        RESUMING   = 5'b10011,
        ABS_REG    = 5'b10100,
        ABS_EXEC   = 5'b10101,
        ABS_RMEM   = 5'b10110,
        ABS_RMEM_1 = 5'b10111,
        BRANCH     = 5'b11000,
        JALR       = 5'b11001,
        JAL        = 5'b11011,
        SYSTEM     = 5'b11100,
        ABS_NA     = 5'b11101,
        ABS_WMEM   = 5'b11110,
        ABS_WMEM_1 = 5'b11111
    } state_t;

    localparam logic [1:0] RD_ALU = 2'b00;
    localparam logic [1:0] RD_MEM = 2'b01;
    localparam logic [1:0] RD_CSR = 2'b10;
    localparam logic [1:0] A1_RS  = 2'b00;
    localparam logic [1:0] A1_PC  = 2'b01;
    localparam logic [1:0] A1_ZR  = 2'b10;
    localparam logic [1:0] A2_RS  = 2'b00;
    localparam logic [1:0] A2_IM  = 2'b01;
    localparam logic [1:0] A2_IS  = 2'b10;

    // Opcodes the execute stage implements.
    function automatic logic legal_opcode(input logic [4:0] op);
        logic ok;
        case (op)
            5'b00000, 5'b00011, 5'b00100, 5'b00101, 5'b01000, 5'b01100,
            5'b01101, 5'b11000, 5'b11001, 5'b11011, 5'b11100: ok = 1'b1;
            default:                                          ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Abstract commands the debug path implements.
    function automatic logic legal_abs_op(input logic [4:0] op);
        logic ok;
        case (op)
            5'b10100, 5'b10101, 5'b10110, 5'b11110: ok = 1'b1;
            default:                                ok = 1'b0;
        endcase
        return ok;
    endfunction

    state_t     state_r, state_s;
    logic       progbuf_r, progbuf_s;

    logic       write_pc_ne_s, write_pc_ex_s, write_ir_s, write_rd_s;
    logic       write_csr_s, mem_read_s, mem_write_s, addr_sel_s;
    logic [1:0] rd_sel_s, alu_insel1_s, alu_insel2_s;
    logic       abstract_write_s, abstract_done_s;

    // State and program-buffer flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= RESET_HALTED ? HALTED : PROLOGUE;
            progbuf_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            progbuf_r <= progbuf_s;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_s          = state_r;
        progbuf_s        = progbuf_r;
        write_pc_ne_s    = 1'b0;
        write_pc_ex_s    = 1'b0;
        write_ir_s       = 1'b0;
        write_rd_s       = 1'b0;
        write_csr_s      = 1'b0;
        mem_read_s       = 1'b0;
        mem_write_s      = 1'b0;
        addr_sel_s       = 1'b0;
        rd_sel_s         = RD_ALU;
        alu_insel1_s     = A1_RS;
        alu_insel2_s     = A2_RS;
        abstract_write_s = 1'b0;
        abstract_done_s  = 1'b0;

        case (state_r)
            PROLOGUE: begin
                // A program-buffer run cannot be interrupted by a halt request.
                if (cs.halt_req && !progbuf_r) begin
                    state_s = HALTED;
                end else begin
                    mem_read_s = 1'b1;
                    write_ir_s = cs.mem_complete;
                    if (cs.mem_complete) begin
                        state_s = DISPATCH;
                    end else begin
                        state_s = PROLOGUE;
                    end
                end
            end
            DISPATCH: begin
                if (legal_opcode(cs.opcode)) begin
                    state_s = state_t'(cs.opcode);
                end else if (HALT_ON_ILLEGAL) begin
                    state_s = HALTED;
                end else begin
                    write_pc_ne_s = 1'b1;
                    state_s       = PROLOGUE;
                end
            end
            LUI, AUIPC: begin
                alu_insel1_s  = (state_r == LUI) ? A1_ZR : A1_PC;
                alu_insel2_s  = A2_IM;
                write_rd_s    = 1'b1;
                write_pc_ne_s = 1'b1;
                state_s       = PROLOGUE;
            end
            JAL, JALR: begin
                alu_insel1_s  = (state_r == JAL) ? A1_PC : A1_RS;
                alu_insel2_s  = A2_IM;
                write_rd_s    = 1'b1;
                write_pc_ex_s = 1'b1;
                state_s       = PROLOGUE;
            end
            BRANCH: begin
                write_pc_ex_s = cs.branch_taken;
                write_pc_ne_s = !cs.branch_taken;
                state_s       = PROLOGUE;
            end
            LOAD, LOAD_W, STORE, STORE_W: begin
                alu_insel2_s = A2_IM;
                addr_sel_s   = 1'b1;
                if ((state_r == LOAD) || (state_r == LOAD_W)) begin
                    mem_read_s = 1'b1;
                    state_s    = cs.mem_complete ? LOAD_1 : LOAD_W;
                end else begin
                    mem_write_s = 1'b1;
                    state_s     = cs.mem_complete ? STORE_1 : STORE_W;
                end
            end
            LOAD_1: begin
                rd_sel_s      = RD_MEM;
                write_rd_s    = 1'b1;
                write_pc_ne_s = 1'b1;
                state_s       = PROLOGUE;
            end
            STORE_1, MISCMEM: begin
                write_pc_ne_s = 1'b1;
                state_s       = PROLOGUE;
            end
            OPIMM, OP: begin
                if (state_r == OP) begin
                    alu_insel2_s = A2_RS;
                end else if ((cs.f3 == 3'b001) || (cs.f3 == 3'b101)) begin
                    alu_insel2_s = A2_IS;
                end else begin
                    alu_insel2_s = A2_IM;
                end
                write_rd_s    = 1'b1;
                write_pc_ne_s = 1'b1;
                state_s       = PROLOGUE;
            end
            SYSTEM: begin
                if (cs.f3 == 3'b000) begin
                    // EBREAK/ECALL: enter debug; closes a program-buffer run.
                    state_s = HALTED;
                    if (progbuf_r) begin
                        abstract_done_s = 1'b1;
                        progbuf_s       = 1'b0;
                    end else begin
                        progbuf_s       = 1'b0;
                    end
                end else if (cs.f3 == 3'b100) begin
                    if (HALT_ON_ILLEGAL) begin
                        state_s = HALTED;
                    end else begin
                        write_pc_ne_s = 1'b1;
                        state_s       = PROLOGUE;
                    end
                end else begin
                    rd_sel_s      = RD_CSR;
                    write_rd_s    = 1'b1;
                    write_csr_s   = 1'b1;
                    write_pc_ne_s = 1'b1;
                    if (cs.f3[2]) begin
                        alu_insel1_s = A1_ZR;
                        alu_insel2_s = A2_IM;
                    end else begin
                        alu_insel1_s = A1_RS;
                    end
                    state_s = PROLOGUE;
                end
            end
            HALTED: begin
                // A pending command takes priority over resume.
                if (cs.abs_valid) begin
                    state_s = legal_abs_op(cs.abs_op) ? state_t'(cs.abs_op) : ABS_NA;
                end else if (cs.resume_req) begin
                    state_s = RESUMING;
                end else begin
                    state_s = HALTED;
                end
            end
            RESUMING: begin
                state_s = PROLOGUE;
            end
            ABS_REG: begin
                abstract_write_s = 1'b1;
                abstract_done_s  = 1'b1;
                state_s          = HALTED;
            end
            ABS_NA: begin
                abstract_done_s = 1'b1;
                state_s         = HALTED;
            end
            ABS_EXEC: begin
                progbuf_s = 1'b1;
                state_s   = PROLOGUE;
            end
            ABS_RMEM: begin
                addr_sel_s = 1'b1;
                mem_read_s = 1'b1;
                state_s    = cs.mem_complete ? ABS_RMEM_1 : ABS_RMEM;
            end
            ABS_RMEM_1: begin
                abstract_write_s = 1'b1;
                abstract_done_s  = 1'b1;
                state_s          = HALTED;
            end
            ABS_WMEM: begin
                addr_sel_s  = 1'b1;
                mem_write_s = 1'b1;
                state_s     = cs.mem_complete ? ABS_WMEM_1 : ABS_WMEM;
            end
            ABS_WMEM_1: begin
                abstract_done_s = 1'b1;
                state_s         = HALTED;
            end
            default: begin
                // Unused codes drive nothing and recover to fetch.
                state_s = PROLOGUE;
            end
        endcase
    end

    // Strobes are forced low while reset is asserted so an in-flight access
    // is dropped immediately rather than at the next clock.
    assign cs.mcp_addr       = state_r;
    assign cs.halted         = (state_r == HALTED);
    assign cs.progbuf        = progbuf_r;
    assign cs.write_pc_ne    = write_pc_ne_s & rst_n;
    assign cs.write_pc_ex    = write_pc_ex_s & rst_n;
    assign cs.write_pc       = (write_pc_ne_s | write_pc_ex_s) & rst_n;
    assign cs.write_ir       = write_ir_s & rst_n;
    assign cs.write_rd       = write_rd_s & rst_n;
    assign cs.write_csr      = write_csr_s & rst_n;
    assign cs.mem_read       = mem_read_s & rst_n;
    assign cs.mem_write      = mem_write_s & rst_n;
    assign cs.addr_sel       = addr_sel_s & rst_n;
    assign cs.rd_sel         = rst_n ? rd_sel_s : 2'b00;
    assign cs.alu_insel1     = rst_n ? alu_insel1_s : 2'b00;
    assign cs.alu_insel2     = rst_n ? alu_insel2_s : 2'b00;
    assign cs.abstract_write = abstract_write_s & rst_n;
    assign cs.abstract_done  = abstract_done_s & rst_n;

endmodule

// File: tb/tb_control_sequencer.sv
// ---------------------------------------------------------------------------
// tb_control_sequencer
// Directed bench for control_sequencer (RESET_HALTED=0, HALT_ON_ILLEGAL=1).
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit
// later, well away from the next edge.
// ---------------------------------------------------------------------------
module tb_control_sequencer;

    localparam logic [4:0] S_LOAD     = 5'b00000;
    localparam logic [4:0] S_LOAD_W   = 5'b00001;
    localparam logic [4:0] S_LOAD_1   = 5'b00010;
    localparam logic [4:0] S_OPIMM    = 5'b00100;
    localparam logic [4:0] S_STORE    = 5'b01000;
    localparam logic [4:0] S_STORE_1  = 5'b01010;
    localparam logic [4:0] S_LUI      = 5'b01101;
    localparam logic [4:0] S_PROLOGUE = 5'b10000;
    localparam logic [4:0] S_DISPATCH = 5'b10001;
    localparam logic [4:0] S_HALTED   = 5'b10010;
    localparam logic [4:0] S_RESUMING = 5'b10011;
    localparam logic [4:0] S_ABS_REG  = 5'b10100;
    localparam logic [4:0] S_ABS_EXEC = 5'b10101;
    localparam logic [4:0] S_ABS_RMEM = 5'b10110;
    localparam logic [4:0] S_ABS_RM1  = 5'b10111;
    localparam logic [4:0] S_BRANCH   = 5'b11000;
    localparam logic [4:0] S_SYSTEM   = 5'b11100;
    localparam logic [4:0] S_ABS_NA   = 5'b11101;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   wr_count;

    control_signals_if cs ();

    control_sequencer #(
        .RESET_HALTED    (1'b0),
        .HALT_ON_ILLEGAL (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .cs    (cs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; return 1 unit after the edge.
    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    // Drive a zero-wait fetch from PROLOGUE; returns in the execute state.
    task automatic fetch(input logic [4:0] op, input logic [2:0] fn);
        cs.opcode       = op;
        cs.f3           = fn;
        cs.mem_complete = 1'b1;
        next_cycle();
        cs.mem_complete = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        cs.mem_complete = 1'b0; cs.opcode = 5'b00000; cs.f3 = 3'b000;
        cs.branch_taken = 1'b0; cs.halt_req = 1'b0; cs.resume_req = 1'b0;
        cs.abs_valid = 1'b0; cs.abs_op = 5'b00000;
        #12;
        checks++; if (cs.mcp_addr !== S_PROLOGUE) begin failures++; $display("FAIL reset_state got=%b exp=%b", cs.mcp_addr, S_PROLOGUE); end
        checks++; if (cs.mem_read !== 1'b0) begin failures++; $display("FAIL reset_mem_read got=%b exp=0", cs.mem_read); end
        checks++; if (cs.progbuf !== 1'b0 || cs.halted !== 1'b0) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", cs.progbuf, cs.halted); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_fetch;
        checks++; if (cs.mem_read !== 1'b1 || cs.addr_sel !== 1'b0 || cs.write_ir !== 1'b0) begin failures++; $display("FAIL fetch_start got rd=%b as=%b ir=%b exp 1 0 0", cs.mem_read, cs.addr_sel, cs.write_ir); end
        next_cycle();
        next_cycle();
        checks++; if (cs.mcp_addr !== S_PROLOGUE) begin failures++; $display("FAIL fetch_wait got=%b exp=%b", cs.mcp_addr, S_PROLOGUE); end
        next_cycle();
        cs.mem_complete = 1'b1;
        cs.opcode = S_LOAD;
        #1;
        checks++; if (cs.write_ir !== 1'b1) begin failures++; $display("FAIL fetch_write_ir got=%b exp=1", cs.write_ir); end
        next_cycle();
        cs.mem_complete = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_DISPATCH || cs.write_ir !== 1'b0) begin failures++; $display("FAIL fetch_dispatch got=%b ir=%b exp=%b ir=0", cs.mcp_addr, cs.write_ir, S_DISPATCH); end
    endtask

    task automatic test_load;
        wr_count = 0;
        next_cycle();
        checks++; if (cs.mcp_addr !== S_LOAD || cs.mem_read !== 1'b1 || cs.addr_sel !== 1'b1 || cs.alu_insel2 !== 2'b01) begin failures++; $display("FAIL load_req got st=%b rd=%b as=%b a2=%b", cs.mcp_addr, cs.mem_read, cs.addr_sel, cs.alu_insel2); end
        wr_count += int'(cs.write_rd);
        next_cycle();
        checks++; if (cs.mcp_addr !== S_LOAD_W || cs.mem_read !== 1'b1) begin failures++; $display("FAIL load_w1 got st=%b rd=%b exp=%b 1", cs.mcp_addr, cs.mem_read, S_LOAD_W); end
        wr_count += int'(cs.write_rd);
        next_cycle();
        cs.mem_complete = 1'b1;
        #1;
        checks++; if (cs.mcp_addr !== S_LOAD_W || cs.addr_sel !== 1'b1) begin failures++; $display("FAIL load_w2 got st=%b as=%b exp=%b 1", cs.mcp_addr, cs.addr_sel, S_LOAD_W); end
        wr_count += int'(cs.write_rd);
        next_cycle();
        cs.mem_complete = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_LOAD_1 || cs.rd_sel !== 2'b01 || cs.write_pc_ne !== 1'b1 || cs.write_pc !== 1'b1) begin failures++; $display("FAIL load_1 got st=%b rs=%b ne=%b pc=%b", cs.mcp_addr, cs.rd_sel, cs.write_pc_ne, cs.write_pc); end
        wr_count += int'(cs.write_rd);
        checks++; if (wr_count !== 1) begin failures++; $display("FAIL load_write_rd_count got=%0d exp=1", wr_count); end
        next_cycle();
        checks++; if (cs.mcp_addr !== S_PROLOGUE) begin failures++; $display("FAIL load_return got=%b exp=%b", cs.mcp_addr, S_PROLOGUE); end
    endtask

    task automatic test_store;
        fetch(S_STORE, 3'b010);
        cs.mem_complete = 1'b1;
        #1;
        checks++; if (cs.mcp_addr !== S_STORE || cs.mem_write !== 1'b1 || cs.mem_read !== 1'b0 || cs.addr_sel !== 1'b1) begin failures++; $display("FAIL store_req got st=%b wr=%b rd=%b as=%b", cs.mcp_addr, cs.mem_write, cs.mem_read, cs.addr_sel); end
        next_cycle();
        cs.mem_complete = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_STORE_1 || cs.write_pc_ne !== 1'b1 || cs.write_rd !== 1'b0 || cs.mem_write !== 1'b0) begin failures++; $display("FAIL store_1 got st=%b ne=%b rd=%b wr=%b", cs.mcp_addr, cs.write_pc_ne, cs.write_rd, cs.mem_write); end
        next_cycle();
    endtask

    task automatic test_branch;
        fetch(S_BRANCH, 3'b000);
        cs.branch_taken = 1'b1;
        #1;
        checks++; if (cs.write_pc_ex !== 1'b1 || cs.write_pc_ne !== 1'b0 || cs.write_pc !== 1'b1) begin failures++; $display("FAIL branch_taken got ex=%b ne=%b pc=%b exp 1 0 1", cs.write_pc_ex, cs.write_pc_ne, cs.write_pc); end
        cs.branch_taken = 1'b0;
        #1;
        checks++; if (cs.write_pc_ex !== 1'b0 || cs.write_pc_ne !== 1'b1 || cs.write_pc !== 1'b1) begin failures++; $display("FAIL branch_not_taken got ex=%b ne=%b pc=%b exp 0 1 1", cs.write_pc_ex, cs.write_pc_ne, cs.write_pc); end
        checks++; if (cs.mcp_addr !== S_BRANCH || cs.write_rd !== 1'b0) begin failures++; $display("FAIL branch_state got st=%b rd=%b", cs.mcp_addr, cs.write_rd); end
        next_cycle();
        checks++; if (cs.mcp_addr !== S_PROLOGUE) begin failures++; $display("FAIL branch_return got=%b exp=%b", cs.mcp_addr, S_PROLOGUE); end
    endtask

    task automatic test_alu_ops;
        fetch(S_LUI, 3'b000);
        checks++; if (cs.alu_insel1 !== 2'b10 || cs.alu_insel2 !== 2'b01 || cs.write_rd !== 1'b1 || cs.write_pc_ne !== 1'b1) begin failures++; $display("FAIL lui got a1=%b a2=%b rd=%b ne=%b", cs.alu_insel1, cs.alu_insel2, cs.write_rd, cs.write_pc_ne); end
        next_cycle();
        fetch(S_OPIMM, 3'b101);
        checks++; if (cs.mcp_addr !== S_OPIMM || cs.alu_insel2 !== 2'b10 || cs.rd_sel !== 2'b00 || cs.write_rd !== 1'b1) begin failures++; $display("FAIL opimm_shift got st=%b a2=%b rs=%b rd=%b", cs.mcp_addr, cs.alu_insel2, cs.rd_sel, cs.write_rd); end
        next_cycle();
        fetch(S_OPIMM, 3'b000);
        checks++; if (cs.alu_insel2 !== 2'b01) begin failures++; $display("FAIL opimm_addi got a2=%b exp=01", cs.alu_insel2); end
        next_cycle();
        fetch(S_SYSTEM, 3'b010);
        checks++; if (cs.rd_sel !== 2'b10 || cs.write_csr !== 1'b1 || cs.write_rd !== 1'b1 || cs.alu_insel1 !== 2'b00 || cs.write_pc_ne !== 1'b1) begin failures++; $display("FAIL csrrs got rs=%b csr=%b rd=%b a1=%b ne=%b", cs.rd_sel, cs.write_csr, cs.write_rd, cs.alu_insel1, cs.write_pc_ne); end
        next_cycle();
        fetch(S_SYSTEM, 3'b110);
        checks++; if (cs.alu_insel1 !== 2'b10 || cs.alu_insel2 !== 2'b01 || cs.write_csr !== 1'b1) begin failures++; $display("FAIL csrrsi got a1=%b a2=%b csr=%b exp 10 01 1", cs.alu_insel1, cs.alu_insel2, cs.write_csr); end
        next_cycle();
        checks++; if (cs.mcp_addr !== S_PROLOGUE) begin failures++; $display("FAIL alu_return got=%b exp=%b", cs.mcp_addr, S_PROLOGUE); end
    endtask

    task automatic test_illegal;
        cs.opcode = 5'b11111;
        cs.mem_complete = 1'b1;
        next_cycle();
        cs.mem_complete = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_DISPATCH || cs.write_pc !== 1'b0) begin failures++; $display("FAIL illegal_dispatch got st=%b pc=%b exp=%b 0", cs.mcp_addr, cs.write_pc, S_DISPATCH); end
        next_cycle();
        checks++; if (cs.mcp_addr !== S_HALTED || cs.halted !== 1'b1) begin failures++; $display("FAIL illegal_halt got st=%b h=%b exp=%b 1", cs.mcp_addr, cs.halted, S_HALTED); end
        cs.resume_req = 1'b1;
        next_cycle();
        cs.resume_req = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_RESUMING || cs.halted !== 1'b0) begin failures++; $display("FAIL resuming got st=%b h=%b exp=%b 0", cs.mcp_addr, cs.halted, S_RESUMING); end
        next_cycle();
        checks++; if (cs.mcp_addr !== S_PROLOGUE) begin failures++; $display("FAIL resume_prologue got=%b exp=%b", cs.mcp_addr, S_PROLOGUE); end
    endtask

    task automatic test_halt_abs;
        cs.halt_req = 1'b1;
        #1;
        checks++; if (cs.mem_read !== 1'b0 || cs.write_ir !== 1'b0) begin failures++; $display("FAIL halt_no_fetch got rd=%b ir=%b exp 0 0", cs.mem_read, cs.write_ir); end
        next_cycle();
        cs.halt_req = 1'b0;
        #1;
        checks++; if (cs.halted !== 1'b1 || cs.mcp_addr !== S_HALTED) begin failures++; $display("FAIL halt_enter got st=%b h=%b", cs.mcp_addr, cs.halted); end
        cs.abs_valid = 1'b1;
        cs.abs_op = S_ABS_RMEM;
        next_cycle();
        cs.abs_valid = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_ABS_RMEM || cs.mem_read !== 1'b1 || cs.addr_sel !== 1'b1 || cs.abstract_done !== 1'b0) begin failures++; $display("FAIL rmem_req got st=%b rd=%b as=%b dn=%b", cs.mcp_addr, cs.mem_read, cs.addr_sel, cs.abstract_done); end
        next_cycle();
        cs.mem_complete = 1'b1;
        next_cycle();
        cs.mem_complete = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_ABS_RM1 || cs.abstract_write !== 1'b1 || cs.abstract_done !== 1'b1) begin failures++; $display("FAIL rmem_done got st=%b aw=%b dn=%b", cs.mcp_addr, cs.abstract_write, cs.abstract_done); end
        next_cycle();
        checks++; if (cs.mcp_addr !== S_HALTED || cs.abstract_done !== 1'b0) begin failures++; $display("FAIL rmem_back got st=%b dn=%b exp=%b 0", cs.mcp_addr, cs.abstract_done, S_HALTED); end
        cs.abs_valid = 1'b1;
        cs.abs_op = 5'b00000;
        next_cycle();
        cs.abs_valid = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_ABS_NA || cs.abstract_done !== 1'b1 || cs.abstract_write !== 1'b0) begin failures++; $display("FAIL abs_na got st=%b dn=%b aw=%b", cs.mcp_addr, cs.abstract_done, cs.abstract_write); end
        next_cycle();
        checks++; if (cs.mcp_addr !== S_HALTED) begin failures++; $display("FAIL abs_na_back got=%b exp=%b", cs.mcp_addr, S_HALTED); end
    endtask

    task automatic test_progbuf;
        cs.abs_valid = 1'b1;
        cs.abs_op = S_ABS_EXEC;
        next_cycle();
        cs.abs_valid = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_ABS_EXEC || cs.progbuf !== 1'b0) begin failures++; $display("FAIL exec_state got st=%b pb=%b", cs.mcp_addr, cs.progbuf); end
        next_cycle();
        cs.halt_req = 1'b1;
        #1;
        checks++; if (cs.mcp_addr !== S_PROLOGUE || cs.progbuf !== 1'b1 || cs.mem_read !== 1'b1) begin failures++; $display("FAIL progbuf_fetch got st=%b pb=%b rd=%b", cs.mcp_addr, cs.progbuf, cs.mem_read); end
        fetch(S_SYSTEM, 3'b000);
        cs.halt_req = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_SYSTEM || cs.abstract_done !== 1'b1 || cs.write_pc !== 1'b0) begin failures++; $display("FAIL ebreak got st=%b dn=%b pc=%b", cs.mcp_addr, cs.abstract_done, cs.write_pc); end
        next_cycle();
        checks++; if (cs.mcp_addr !== S_HALTED || cs.progbuf !== 1'b0 || cs.abstract_done !== 1'b0) begin failures++; $display("FAIL ebreak_halt got st=%b pb=%b dn=%b", cs.mcp_addr, cs.progbuf, cs.abstract_done); end
    endtask

    task automatic test_back_to_back;
        cs.abs_valid = 1'b1;
        cs.abs_op = S_ABS_REG;
        cs.resume_req = 1'b1;
        next_cycle();
        cs.abs_valid = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_ABS_REG || cs.abstract_write !== 1'b1 || cs.abstract_done !== 1'b1) begin failures++; $display("FAIL cmd_first got st=%b aw=%b dn=%b", cs.mcp_addr, cs.abstract_write, cs.abstract_done); end
        next_cycle();
        checks++; if (cs.mcp_addr !== S_HALTED) begin failures++; $display("FAIL cmd_back got=%b exp=%b", cs.mcp_addr, S_HALTED); end
        next_cycle();
        cs.resume_req = 1'b0;
        #1;
        checks++; if (cs.mcp_addr !== S_RESUMING) begin failures++; $display("FAIL b2b_resuming got=%b exp=%b", cs.mcp_addr, S_RESUMING); end
        next_cycle();
        checks++; if (cs.mcp_addr !== S_PROLOGUE) begin failures++; $display("FAIL b2b_prologue got=%b exp=%b", cs.mcp_addr, S_PROLOGUE); end
    endtask

    task automatic test_async_reset;
        cs.halt_req = 1'b1;
        next_cycle();
        cs.halt_req = 1'b0;
        cs.abs_valid = 1'b1;
        cs.abs_op = S_ABS_EXEC;
        next_cycle();
        cs.abs_valid = 1'b0;
        next_cycle();
        checks++; if (cs.progbuf !== 1'b1 || cs.mem_read !== 1'b1) begin failures++; $display("FAIL pre_reset got pb=%b rd=%b exp 1 1", cs.progbuf, cs.mem_read); end
        rst_n = 1'b0;
        #1;
        checks++; if (cs.progbuf !== 1'b0 || cs.mem_read !== 1'b0 || cs.mcp_addr !== S_PROLOGUE) begin failures++; $display("FAIL async_reset got pb=%b rd=%b st=%b", cs.progbuf, cs.mem_read, cs.mcp_addr); end
        next_cycle();
        rst_n = 1'b1;
        #1;
        checks++; if (cs.mem_read !== 1'b1 || cs.mcp_addr !== S_PROLOGUE) begin failures++; $display("FAIL post_reset got rd=%b st=%b", cs.mem_read, cs.mcp_addr); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks = 0;
        failures = 0;
        wr_count = 0;
        test_reset();
        test_fetch();
        test_load();
        test_store();
        test_branch();
        test_alu_ops();
        test_illegal();
        test_halt_abs();
        test_progbuf();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
